// File: rtl/pattern_stepper.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_stepper
//  Purpose  : Drum step sequencer. Walks a STEPS x SBITS sample map at a
//             step rate expressed in 1 ms ticks. Presents the current sample
//             code with a one-cycle trigger. New maps are held pending and
//             swapped in only at the bar wrap, or immediately while idle or
//             starting.
//  Config   : PATTERN_STEPPER_SWING_EN - when defined, even steps last
//             len + len/4 ticks and odd steps len - len/4 (minimum 1).
//  Ports    : clk, nrst (async, active-low)
//             tick_ms    - 1 ms strobe, one clk wide
//             run        - 1 = play, 0 = stop and rewind
//             eight_note - step length in ms (0 behaves as 1)
//             map_in     - candidate map, step n at [SBITS*n +: SBITS]
//             map_load   - one-cycle capture request for map_in
//             load_ack   - pulses when a captured map becomes active
//             sample_out - sample code of the current step (0 = rest)
//             trig       - pulses at step start when sample code != 0
//             step_idx   - current step number
//             bar_start  - pulses when step 0 starts
//  Revision : 1.0 - initial release
// ============================================================================
module pattern_stepper #(
    parameter int STEPS = 32,
    parameter int SBITS = 3,
    parameter int DW    = 10
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       tick_ms,
    input  logic                       run,
    input  logic [DW-1:0]              eight_note,
    input  logic [STEPS*SBITS-1:0]     map_in,
    input  logic                       map_load,
    output logic                       load_ack,
    output logic [SBITS-1:0]           sample_out,
    output logic                       trig,
    output logic [$clog2(STEPS)-1:0]   step_idx,
    output logic                       bar_start
);

    localparam int              c_IW        = $clog2(STEPS);
    localparam int              c_MW        = STEPS * SBITS;
    localparam int              c_BW        = $clog2(c_MW);
    localparam logic [1:0]      c_ST_IDLE   = 2'd0;
    localparam logic [1:0]      c_ST_START  = 2'd1;
    localparam logic [1:0]      c_ST_PLAY   = 2'd2;
    localparam logic [c_IW-1:0] c_LAST_STEP = c_IW'(STEPS - 1);
    localparam logic [DW:0]     c_LEN_ONE   = (DW+1)'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_IW-1:0]  r_step;
    logic [c_IW-1:0]  w_step_nxt;
    logic [SBITS-1:0] r_sample;
    logic [SBITS-1:0] w_sample_nxt;
    logic [DW-1:0]    r_ms_cnt;
    logic [DW-1:0]    w_ms_nxt;
    logic             r_trig;
    logic             w_trig_nxt;
    logic             r_bar;
    logic             w_bar_nxt;
    logic             r_ack;
    logic             w_ack_nxt;
    logic [c_MW-1:0]  r_active;
    logic [c_MW-1:0]  r_pending;
    logic             r_pend_vld;

    logic [DW-1:0]    w_len_base;
    logic [DW:0]      w_step_len;
    logic             w_ms_sat;
    logic             w_step_done;
    logic             w_advance;
    logic             w_wrap;
    logic             w_apply;
    logic [c_MW-1:0]  w_map_sel;
    logic [c_IW-1:0]  w_next_step;
    logic [c_BW-1:0]  w_bit_base;
    logic [SBITS-1:0] w_next_code;

    // ------------------------------------------------------------------
    // Step length
    // ------------------------------------------------------------------
    assign w_len_base = (eight_note == '0) ? DW'(1) : eight_note;

`ifdef PATTERN_STEPPER_SWING_EN
    logic [DW-1:0] w_quarter;
    logic [DW-1:0] w_odd_raw;
    logic [DW-1:0] w_odd_len;

    assign w_quarter  = w_len_base >> 2;
    assign w_odd_raw  = w_len_base - w_quarter;
    assign w_odd_len  = (w_odd_raw == '0) ? DW'(1) : w_odd_raw;
    // Long step on even indices, short on odd; the extra bit holds len*1.25.
    assign w_step_len = r_step[0] ? {1'b0, w_odd_len}
                                  : ({1'b0, w_len_base} + {1'b0, w_quarter});
`else
    assign w_step_len = {1'b0, w_len_base};
`endif

    assign w_ms_sat = &r_ms_cnt;
    // Comparing with >= lets a shrinking eight_note end the step on the next
    // tick. A saturated counter also ends the step, so a swung length beyond
    // the counter range can never stall the sequencer.
    assign w_step_done = ({1'b0, r_ms_cnt} >= (w_step_len - c_LEN_ONE)) || w_ms_sat;

    assign w_advance = (r_state == c_ST_PLAY) && run && tick_ms && w_step_done;
    assign w_wrap    = w_advance && (r_step == c_LAST_STEP);

    // A pending map goes live while idle/starting, or exactly at the bar wrap.
    assign w_apply   = r_pend_vld &&
                       ((r_state == c_ST_IDLE) || (r_state == c_ST_START) || w_wrap);

    // The step being entered reads from the map that is active after this edge.
    assign w_map_sel   = w_apply ? r_pending : r_active;
    assign w_next_step = (r_state == c_ST_PLAY) ? (r_step + c_IW'(1)) : '0;
    assign w_bit_base  = c_BW'(w_next_step) * c_BW'(SBITS);
    assign w_next_code = w_map_sel[w_bit_base +: SBITS];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (run) w_state_nxt = c_ST_START;
            c_ST_START: w_state_nxt = c_ST_PLAY;
            c_ST_PLAY:  w_state_nxt = c_ST_PLAY;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
        // Dropping run rewinds from anywhere on the next edge.
        if (!run) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_step_nxt   = r_step;
        w_sample_nxt = r_sample;
        w_ms_nxt     = r_ms_cnt;
        w_trig_nxt   = 1'b0;
        w_bar_nxt    = 1'b0;
        w_ack_nxt    = w_apply;
        if (!run || (r_state == c_ST_IDLE)) begin
            w_step_nxt   = '0;
            w_sample_nxt = '0;
            w_ms_nxt     = '0;
        end else if (r_state == c_ST_START) begin
            w_step_nxt   = '0;
            w_sample_nxt = w_next_code;
            w_ms_nxt     = '0;
            w_bar_nxt    = 1'b1;
            w_trig_nxt   = |w_next_code;
        end else if ((r_state == c_ST_PLAY) && tick_ms) begin
            if (w_step_done) begin
                w_ms_nxt     = '0;
                w_step_nxt   = w_next_step;
                w_sample_nxt = w_next_code;
                w_trig_nxt   = |w_next_code;
                w_bar_nxt    = w_wrap;
            end else if (!w_ms_sat) begin
                w_ms_nxt = r_ms_cnt + DW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath and map registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_step     <= '0;
            r_sample   <= '0;
            r_ms_cnt   <= '0;
            r_trig     <= 1'b0;
            r_bar      <= 1'b0;
            r_ack      <= 1'b0;
            r_active   <= '0;
            r_pending  <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            r_step   <= w_step_nxt;
            r_sample <= w_sample_nxt;
            r_ms_cnt <= w_ms_nxt;
            r_trig   <= w_trig_nxt;
            r_bar    <= w_bar_nxt;
            r_ack    <= w_ack_nxt;
            if (w_apply) begin
                r_active <= r_pending;
            end
            // A load coinciding with an apply becomes the next pending map.
            if (map_load) begin
                r_pending  <= map_in;
                r_pend_vld <= 1'b1;
            end else if (w_apply) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    assign step_idx   = r_step;
    assign sample_out = r_sample;
    assign trig       = r_trig;
    assign bar_start  = r_bar;
    assign load_ack   = r_ack;

endmodule

`default_nettype wire

// File: tb/tb_pattern_stepper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pattern_stepper
//  Purpose  : Self-checking bench for pattern_stepper. A reference model
//             predicts every output event (step change, sample change or
//             pulse) with its cycle number into a queue; a monitor compares
//             DUT events against that queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_stepper;

    localparam int STEPS = 32;
    localparam int SBITS = 3;
    localparam int DW    = 10;

    typedef int map_t [STEPS];

    typedef struct {
        int cyc;
        int step;
        int smp;
        bit trig;
        bit bar;
        bit ack;
    } ev_t;

    logic                   clk = 1'b0;
    logic                   nrst = 1'b0;
    logic                   tick_ms = 1'b0;
    logic                   run = 1'b0;
    logic [DW-1:0]          eight_note = '0;
    logic [STEPS*SBITS-1:0] map_in = '0;
    logic                   map_load = 1'b0;
    logic                   load_ack;
    logic [SBITS-1:0]       sample_out;
    logic                   trig;
    logic [4:0]             step_idx;
    logic                   bar_start;

    pattern_stepper dut (
        .clk        (clk),
        .nrst       (nrst),
        .tick_ms    (tick_ms),
        .run        (run),
        .eight_note (eight_note),
        .map_in     (map_in),
        .map_load   (map_load),
        .load_ack   (load_ack),
        .sample_out (sample_out),
        .trig       (trig),
        .step_idx   (step_idx),
        .bar_start  (bar_start)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_err    = 0;
    int  cyc      = 0;
    ev_t sb[$];

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    map_t m_act;
    map_t m_pen;
    bit   m_pv;
    int   m_phase;      // 0 idle, 1 start, 2 playing
    int   m_step;
    int   m_smp;
    int   m_ms;
    int   m_pstep;
    int   m_psmp;

    function automatic map_t unpack_map(input logic [STEPS*SBITS-1:0] m);
        map_t a;
        for (int n = 0; n < STEPS; n++) a[n] = int'(m[SBITS*n +: SBITS]);
        return a;
    endfunction

    function automatic int step_len(input int en, input int step);
        int l;
        l = (en == 0) ? 1 : en;
`ifdef PATTERN_STEPPER_SWING_EN
        if (step % 2 == 0) l = l + l / 4;
        else begin
            l = l - l / 4;
            if (l < 1) l = 1;
        end
`endif
        return l;
    endfunction

    always @(posedge clk or negedge nrst) begin
        bit e_trig;
        bit e_bar;
        bit e_ack;
        int len;
        if (!nrst) begin
            m_phase = 0; m_step = 0; m_smp = 0; m_ms = 0; m_pv = 0;
            m_pstep = 0; m_psmp = 0;
            for (int i = 0; i < STEPS; i++) begin m_act[i] = 0; m_pen[i] = 0; end
            sb.delete();
        end else begin
            cyc++;
            e_trig = 0; e_bar = 0; e_ack = 0;
            if (m_phase == 0) begin
                if (m_pv) begin m_act = m_pen; m_pv = 0; e_ack = 1; end
                m_step = 0; m_smp = 0; m_ms = 0;
                if (run) m_phase = 1;
            end else if (m_phase == 1) begin
                if (m_pv) begin m_act = m_pen; m_pv = 0; e_ack = 1; end
                m_step = 0; m_ms = 0;
                if (run) begin
                    m_smp = m_act[0]; e_bar = 1; e_trig = (m_smp != 0); m_phase = 2;
                end else begin
                    m_smp = 0; m_phase = 0;
                end
            end else begin
                if (!run) begin
                    m_step = 0; m_smp = 0; m_ms = 0; m_phase = 0;
                end else if (tick_ms) begin
                    len = step_len(int'(eight_note), m_step);
                    if (m_ms >= len - 1 || m_ms == 1023) begin
                        m_ms = 0;
                        m_step = (m_step + 1) % STEPS;
                        if (m_step == 0) begin
                            e_bar = 1;
                            if (m_pv) begin m_act = m_pen; m_pv = 0; e_ack = 1; end
                        end
                        m_smp = m_act[m_step];
                        e_trig = (m_smp != 0);
                    end else if (m_ms < 1023) begin
                        m_ms++;
                    end
                end
            end
            if (map_load) begin m_pen = unpack_map(map_in); m_pv = 1; end
            if (e_trig || e_bar || e_ack || m_step != m_pstep || m_smp != m_psmp)
                sb.push_back('{cyc, m_step, m_smp, e_trig, e_bar, e_ack});
            m_pstep = m_step;
            m_psmp  = m_smp;
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int d_step = 0;
    int d_smp  = 0;

    always @(negedge clk) begin
        ev_t e;
        if (nrst) begin
            if (trig || bar_start || load_ack ||
                int'(step_idx) != d_step || int'(sample_out) != d_smp) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL event: unexpected at cyc=%0d got step=%0d smp=%0d trig=%0b bar=%0b ack=%0b, required no event",
                             cyc, step_idx, sample_out, trig, bar_start, load_ack);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.step != int'(step_idx) || e.smp != int'(sample_out) ||
                        e.trig != trig || e.bar != bar_start || e.ack != load_ack) begin
                        n_err++;
                        $display("FAIL event: got cyc=%0d step=%0d smp=%0d trig=%0b bar=%0b ack=%0b, required cyc=%0d step=%0d smp=%0d trig=%0b bar=%0b ack=%0b",
                                 cyc, step_idx, sample_out, trig, bar_start, load_ack,
                                 e.cyc, e.step, e.smp, e.trig, e.bar, e.ack);
                    end
                end
            end
        end
        d_step = int'(step_idx);
        d_smp  = int'(sample_out);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int tper = 2;
    int tph  = 0;

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            map_load = 1'b0;
            tick_ms  = (tph % tper == 0);
            tph++;
        end
    endtask

    task automatic load_map(input logic [STEPS*SBITS-1:0] m);
        map_in   = m;
        map_load = 1'b1;
    endtask

    task automatic wait_step(input int s);
        int k;
        k = 0;
        while (m_step != s && k < 4000) begin
            cycles(1);
            k++;
        end
        if (m_step != s) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_step: step=%0d after %0d cycles, required %0d", m_step, k, s);
        end
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if (step_idx !== '0 || sample_out !== '0 || trig !== 1'b0 ||
            bar_start !== 1'b0 || load_ack !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got step=%0d smp=%0d trig=%0b bar=%0b ack=%0b, required all 0",
                     name, step_idx, sample_out, trig, bar_start, load_ack);
        end
    endtask

    function automatic logic [STEPS*SBITS-1:0] build_map(input int kind);
        logic [STEPS*SBITS-1:0] m;
        logic [31:0] r;
        m = '0;
        for (int n = 0; n < STEPS; n++) begin
            r = $urandom;
            case (kind)
                0:       m[SBITS*n +: SBITS] = 3'((n % 7) + 1);
                1:       m[SBITS*n +: SBITS] = (n % 2 == 0) ? 3'd0 : 3'(r[2:0] | 3'd1);
                default: m[SBITS*n +: SBITS] = r[2:0];
            endcase
        end
        return m;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        nrst = 1'b1;

        // Incrementing codes, 4 ms steps, map loaded while idle.
        eight_note = 10'd4;
        tper = 2;
        cycles(2);
        load_map(build_map(0));
        cycles(3);
        run = 1'b1;
        cycles(600);

        // Even steps silent, swapped in at the next wrap.
        load_map(build_map(1));
        cycles(300);

        // Load at step 10, active from the following bar.
        wait_step(10);
        load_map(build_map(2));
        cycles(1);
        wait_step(0);
        wait_step(5);

        // Two loads before the wrap: last one wins.
        wait_step(3);
        load_map(build_map(2));
        cycles(10);
        load_map(build_map(2));
        wait_step(0);
        wait_step(2);

        // Zero length and shrinking length.
        tper = 1;
        eight_note = 10'd0;
        cycles(70);
        eight_note = 10'd20;
        wait_step(m_step + 1 == STEPS ? 0 : m_step + 1);
        cycles(11);
        eight_note = 10'd2;
        cycles(20);

        // Run dropped mid-bar then raised.
        eight_note = 10'd3;
        wait_step(17);
        run = 1'b0;
        cycles(5);
        run = 1'b1;
        cycles(40);

        // Asynchronous reset mid-bar.
        wait_step(9);
        #2 nrst = 1'b0;
        #1 check_zero("async_reset");
        cycles(2);
        nrst = 1'b1;
        load_map(build_map(0));
        cycles(100);

        // Randomised play.
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            tick_ms  = ($urandom_range(0, 1) == 1);
            map_load = 1'b0;
            if ($urandom_range(0, 199) == 0) eight_note = 10'($urandom_range(0, 6));
            if ($urandom_range(0, 149) == 0) begin
                map_in   = build_map(2);
                map_load = 1'b1;
            end
            if (run && $urandom_range(0, 299) == 0) run = 1'b0;
            else if (!run && $urandom_range(0, 9) == 0) run = 1'b1;
        end

        run = 1'b0;
        cycles(6);
        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected events never seen, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
